// File: rtl/frequency_divider.sv
// Purpose : selectable integer divider, out = clk / N with N picked from an 8-entry table by select.
// Latency : out rises on the first edge with reset high; select changes apply at the next period wrap.
// Backpressure: none, free-running; out is a registered level, never a generated clock.
module frequency_divider #(
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] select,
  output logic       out
);

  logic [2:0]       sel_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last;   // N - 1 for the latched select
  logic [CNT_W-1:0] high;   // ceil(N / 2): cycles out stays high per period

  // Decode the latched select into the period end and the high-phase length.
  always_comb begin
    last = '0;
    high = '0;
    case (sel_q)
      3'd0:    begin last = CNT_W'(1);  high = CNT_W'(1); end  // /2
      3'd1:    begin last = CNT_W'(2);  high = CNT_W'(2); end  // /3
      3'd2:    begin last = CNT_W'(3);  high = CNT_W'(2); end  // /4
      3'd3:    begin last = CNT_W'(4);  high = CNT_W'(3); end  // /5
      3'd4:    begin last = CNT_W'(5);  high = CNT_W'(3); end  // /6
      3'd5:    begin last = CNT_W'(7);  high = CNT_W'(4); end  // /8
      3'd6:    begin last = CNT_W'(9);  high = CNT_W'(5); end  // /10
      default: begin last = CNT_W'(15); high = CNT_W'(8); end  // /16
    endcase
  end

  // Phase counter, output register and select latch; select is only taken at
  // reset or at the period wrap so a running period is never truncated.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt   <= '0;
      out   <= 1'b0;
      sel_q <= select;
    end else begin
      out <= (cnt < high);
      if (cnt == last) begin
        cnt   <= '0;
        sel_q <= select;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_frequency_divider.sv
// Self-checking bench for frequency_divider: every cycle out is compared with a
// reference that plays back whole periods (H ones then N-H zeros) from a queue.
// Directed phases cover reset, /3, select change mid-period, mid-run reset, a sweep and random traffic.
module tb_frequency_divider;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] select = 3'd0;
  logic       out;

  int errors = 0;
  int checks = 0;

  int   ntab [8] = '{2, 3, 4, 5, 6, 8, 10, 16};
  bit   per_q[$];          // remaining output bits of the period in progress
  logic [2:0] lat = 3'd0;  // divisor select governing the next period
  logic exp_out = 1'b0;

  frequency_divider #(.CNT_W(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .select (select),
    .out    (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, want, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the reference at the edge, check out after it.
  task automatic tick(input logic r, input logic [2:0] s, input string tag);
    int n;
    int h;
    reset  = r;
    select = s;
    @(posedge clk);
    if (!r) begin
      per_q.delete();
      lat     = s;
      exp_out = 1'b0;
    end else begin
      if (per_q.size() == 0) begin
        n = ntab[lat];
        h = (n + 1) / 2;
        for (int i = 0; i < n; i++) per_q.push_back(i < h);
      end
      exp_out = per_q.pop_front();
      if (per_q.size() == 0) lat = s;
    end
    @(negedge clk);
    chk(tag, {31'd0, out}, {31'd0, exp_out});
  endtask

  initial begin
    logic [15:0] pat;
    logic [9:0]  pat10;
    logic        bits [64];
    int          n;
    int          hc;
    int          per;
    logic [2:0]  rs;
    logic        rr;

    @(negedge clk);

    // Reset then /3 for 100 cycles
    for (int i = 0; i < 3; i++) tick(1'b0, 3'd1, "reset_out");
    for (int i = 0; i < 100; i++) tick(1'b1, 3'd1, "div3");

    // Select change mid-period: /8 running, switch to /4 at cnt=3
    for (int i = 0; i < 2; i++) tick(1'b0, 3'd5, "reset_div8");
    for (int i = 0; i < 3; i++) tick(1'b1, 3'd5, "div8_head");
    pat = '0;
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, 3'd2, "sel_change");
      pat = {pat[14:0], out};
    end
    chk("sel_change_pat", {16'd0, pat}, {16'd0, 16'b1000_0110_0110_0110});

    // Reset mid-operation while out is high in /10
    for (int i = 0; i < 2; i++) tick(1'b0, 3'd6, "reset_div10");
    for (int i = 0; i < 3; i++) tick(1'b1, 3'd6, "div10_head");
    chk("div10_high_before_reset", {31'd0, out}, 32'd1);
    tick(1'b0, 3'd6, "mid_reset");
    pat10 = '0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 3'd6, "div10_restart");
      pat10 = {pat10[8:0], out};
    end
    chk("div10_restart_pat", {22'd0, pat10}, {22'd0, 10'b11111_00000});

    // Sweep every select: measured period and high count against the table
    for (int s = 0; s < 8; s++) begin
      n = ntab[s];
      for (int i = 0; i < 2; i++) tick(1'b0, 3'(s), "sweep_reset");
      for (int i = 0; i < 2 * n; i++) begin
        tick(1'b1, 3'(s), "sweep_run");
        bits[i] = out;
      end
      hc  = 0;
      per = 0;
      for (int i = 0; i < n; i++) if (bits[i] === 1'b1) hc++;
      for (int i = 1; i < 2 * n; i++)
        if (per == 0 && bits[i] === 1'b1 && bits[i-1] === 1'b0) per = i;
      chk($sformatf("sweep_high_sel%0d", s), hc, (n + 1) / 2);
      chk($sformatf("sweep_period_sel%0d", s), per, n);
    end

    // Random reset and select traffic
    rs = 3'($urandom_range(0, 7));
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 5) == 0) rs = 3'($urandom_range(0, 7));
      tick(rr, rs, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frequency_divider.md
Name: frequency_divider

Overview:
- Selectable integer clock divider.
- Produces a single-bit output square wave at clk/N, where N is chosen from a fixed 8-entry table by a 3-bit select.
- Used as a tick/slow-clock source for downstream logic.
- Fully synchronous to one clock; output is a registered signal, not a generated clock tree.

Parameters:
CNT_W, 4, width of internal period counter; must hold max divisor-1 (15).

Ports:
clk     input   1  system clock, all state updates on rising edge
reset   input   1  synchronous active-low reset (0 = reset asserted)
select  input   3  divide-ratio select, decoded per table below
out     output  1  divided output, registered

Behaviour:
- Divisor table, N by select:
  - 000 -> 2
  - 001 -> 3
  - 010 -> 4
  - 011 -> 5
  - 100 -> 6
  - 101 -> 8
  - 110 -> 10
  - 111 -> 16
- High-phase length H = ceil(N/2); low phase = N - H. For odd N, out is high one cycle longer than low:
  - N=3: 2 high / 1 low
  - N=5: 3 high / 2 low
- Internal state:
  - sel_q: 3-bit latched select.
  - cnt: CNT_W-bit phase counter.
  - out: output register.
- Reset is synchronous and active-low. On a rising clk edge with reset=0:
  - cnt <= 0
  - out <= 0
  - sel_q <= select
- Normal operation, on a rising edge with reset=1:
  - out <= (cnt < H(sel_q)).
  - If cnt == N(sel_q)-1: cnt <= 0 and sel_q <= select (period boundary).
  - Otherwise cnt <= cnt+1, and sel_q holds.
- Latency:
  - out first goes high on the first rising edge at which reset is sampled 1.
  - Each subsequent period is exactly N clk cycles: H cycles high, then N-H cycles low, repeating.
- Select changes:
  - A change takes effect only at the next period boundary (cnt wrap). This produces no truncated or glitched periods.
  - The period in progress completes with the old N.
  - A change while in reset is captured immediately, since sel_q loads every reset cycle.
- Reset mid-operation:
  - Takes effect at the next rising edge regardless of cnt.
  - out goes 0 at that edge.
  - After release, the sequence restarts from cnt=0.
- No combinational path from select or reset to out; out changes only at rising clk edges.
- Counter never exceeds N-1 for the active sel_q; there are no undefined states.

Test Plan:
- Reset then /3:
  - Stimulus: select=001, reset=0 for 3 edges, then reset=1.
  - Required: out=0 during reset; after release, out pattern 1,1,0 repeating (period 3 cycles) for 100 cycles.
- /2 and /16:
  - select=000 -> out toggles every cycle, 1,0,1,0...
  - select=111 (after reset) -> 8 high, 8 low, period 16.
- Odd duty /5:
  - Stimulus: select=011.
  - Required: 3 high, 2 low repeating; measured high count per period = 3, low count = 2.
- Select change mid-period:
  - Stimulus: running /8 (101); switch select to 010 at cnt=3.
  - Required: current period finishes with 4 high / 4 low, then 2 high / 2 low periods begin exactly at the wrap.
- Reset mid-operation:
  - Stimulus: running /10; assert reset=0 for 1 edge while out=1.
  - Required: out=0 at that edge; on release, 5 high / 5 low restarts from the first edge.
- Sweep all selects:
  - Stimulus: each select value, held in reset then released.
  - Required: measured period equals the table N and the high count equals ceil(N/2) for all 8 codes.
